div_unit: RTL

- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; sits in the EX stage beside the combinational ALU.
- The ALU no longer computes division; the EX stage sends DIV/DIVU operands here and stalls until ready_o.
- The packed result {remainder, quotient} is written to the HI/LO register path: HI = remainder, LO = quotient.

---
 rtl/div_if.sv | 23 ++
 rtl/div_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/div_if.sv
// Handshake between the EX stage and the multi-cycle divider.
// The EX stage drives the request side; the divider returns {hi, lo} and ready.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle on
// operand magnitudes, signs restored on the edge that enters DONE.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DZERO = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               dvd_neg;
  logic               dsr_neg;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = '0;
    ready_d   = 1'b0;

    // quo_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter from the bottom.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    q_bit    = ~trial[WIDTH];
    rem_step = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], q_bit};

    dvd_neg  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    dsr_neg  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];

    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          quo_d     = cond_neg(bus.opdata1_i, dvd_neg);
          dsr_d     = cond_neg(bus.opdata2_i, dsr_neg);
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = dvd_neg ^ dsr_neg;
          neg_rem_d = dvd_neg;
          state_d   = (bus.opdata2_i == '0) ? DZERO : BUSY;
        end
      end
      BUSY: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {cond_neg(rem_step, neg_rem_q), cond_neg(quo_step, neg_quo_q)};
          end
        end
      end
      DZERO: begin
        // Divide by zero is defined to return 0 without a trap.
        state_d = bus.annul_i ? IDLE : DONE;
        ready_d = ~bus.annul_i;
      end
      DONE: begin
        if (bus.annul_i || !bus.start_i) begin
          state_d = IDLE;
        end else begin
          ready_d  = 1'b1;
          result_d = result_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
